// File: rtl/nabp_multi_bank_filtered_ram.sv
// Multi-bank ping-pong store for filtered projection lines: the host fills banks round-robin
// while processors read the working bank through independent one-cycle-latency ports.
module nabp_multi_bank_filtered_ram #(
  parameter int NUM_BANKS           = 3,
  parameter int NUM_READERS         = 2,
  parameter int kAngleLength        = 8,
  parameter int kSLength            = 9,
  parameter int kFilteredDataLength = 12,
  parameter int kDepth              = 256
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      hs_fill_start,
  input  logic [kAngleLength-1:0]                   hs_angle,
  input  logic                                      hs_val_valid,
  input  logic [kFilteredDataLength-1:0]            hs_val,
  input  logic                                      hs_has_next_angle,
  output logic                                      hs_fill_ready,
  output logic                                      hs_fill_done,
  input  logic                                      pr_next_angle,
  output logic                                      pr_next_angle_ack,
  output logic [kAngleLength-1:0]                   pr_angle,
  output logic                                      pr_working,
  input  logic [NUM_READERS*kSLength-1:0]           pr_s_val,
  output logic [NUM_READERS*kFilteredDataLength-1:0] pr_val,
  output logic                                      all_done
);

  localparam int PW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int AW = (kDepth > 1) ? $clog2(kDepth) : 1;
  localparam int DW = kFilteredDataLength;

  typedef enum logic [1:0] {ST_EMPTY, ST_FILLING, ST_FULL, ST_WORKING} bank_st_e;

  bank_st_e                      r_st [NUM_BANKS];
  bank_st_e                      w_st_nxt [NUM_BANKS];
  logic [kAngleLength-1:0]       r_angle [NUM_BANKS];
  logic [DW-1:0]                 r_mem [NUM_BANKS][kDepth];
  logic [PW-1:0]                 r_wr_ptr, r_rd_ptr, w_wr_ptr_nxt, w_rd_ptr_nxt, w_rd_cand;
  logic [AW-1:0]                 r_cnt;
  logic                          r_fill_done, r_ack, r_all_done;
  logic [NUM_READERS*DW-1:0]     r_pr_val;
  logic                          w_any_filling, w_any_full, w_any_working;
  logic                          w_fill_ready, w_start, w_wr_en, w_last, w_swap, w_drain;
  logic [kSLength-1:0]           w_s [NUM_READERS];
  logic [AW-1:0]                 w_rd_addr [NUM_READERS];
  logic [NUM_READERS-1:0]        w_rd_ok;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(NUM_BANKS - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    w_any_filling = 1'b0;
    w_any_full    = 1'b0;
    w_any_working = 1'b0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (r_st[b] == ST_FILLING) w_any_filling = 1'b1;
      if (r_st[b] == ST_FULL)    w_any_full    = 1'b1;
      if (r_st[b] == ST_WORKING) w_any_working = 1'b1;
    end
    w_fill_ready = !w_any_filling && (r_st[r_wr_ptr] == ST_EMPTY);
    w_start      = hs_fill_start && w_fill_ready;
    w_wr_en      = hs_val_valid && (r_st[r_wr_ptr] == ST_FILLING);
    w_last       = w_wr_en && (r_cnt == AW'(kDepth - 1));
    w_rd_cand    = w_any_working ? f_inc(r_rd_ptr) : r_rd_ptr;
    w_swap       = pr_next_angle && (r_st[w_rd_cand] == ST_FULL);
    w_drain      = pr_next_angle && !hs_has_next_angle && !w_any_filling && !w_any_full;
  end

  // Next-state: fill side and swap side always touch different banks, so both apply together.
  // A drain also steps rd_ptr past the released bank so it stays aligned with wr_ptr.
  always_comb begin
    w_st_nxt     = r_st;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    if (w_start) w_st_nxt[r_wr_ptr] = ST_FILLING;
    if (w_last) begin
      w_st_nxt[r_wr_ptr] = ST_FULL;
      w_wr_ptr_nxt       = f_inc(r_wr_ptr);
    end
    if ((w_swap || w_drain) && w_any_working) w_st_nxt[r_rd_ptr] = ST_EMPTY;
    if (w_swap) w_st_nxt[w_rd_cand] = ST_WORKING;
    if (w_swap || w_drain) w_rd_ptr_nxt = w_rd_cand;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        r_st[b]    <= ST_EMPTY;
        r_angle[b] <= '0;
      end
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      r_fill_done <= 1'b0;
      r_ack       <= 1'b0;
      r_all_done  <= 1'b0;
    end else begin
      r_st        <= w_st_nxt;
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_fill_done <= w_last;
      r_ack       <= w_swap;
      if (w_start) begin
        r_angle[r_wr_ptr] <= hs_angle;
        r_cnt             <= '0;
      end else if (w_wr_en) begin
        r_cnt <= r_cnt + AW'(1);
      end
      if (w_drain) r_all_done <= 1'b1;
      if (w_start) r_all_done <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr][r_cnt] <= hs_val;
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_READERS; i++) begin
      w_s[i]       = pr_s_val[i*kSLength +: kSLength];
      w_rd_addr[i] = w_s[i][AW-1:0];
      w_rd_ok[i]   = pr_working && !w_s[i][kSLength-1]
                     && (32'(w_s[i][kSLength-2:0]) < 32'(kDepth));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pr_val <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_READERS; i++)
        r_pr_val[i*DW +: DW] <= w_rd_ok[i] ? r_mem[r_rd_ptr][w_rd_addr[i]] : '0;
    end
  end

  always_comb begin
    hs_fill_ready     = w_fill_ready && !reset;
    hs_fill_done      = r_fill_done;
    pr_next_angle_ack = r_ack;
    pr_working        = (r_st[r_rd_ptr] == ST_WORKING);
    pr_angle          = pr_working ? r_angle[r_rd_ptr] : '0;
    pr_val            = r_pr_val;
    all_done          = r_all_done;
  end

endmodule

// File: tb/tb_nabp_multi_bank_filtered_ram.sv
// Directed bench for nabp_multi_bank_filtered_ram (3 banks, 2 readers, 8-deep lines);
// read results are checked through an expected-value queue.
module tb_nabp_multi_bank_filtered_ram;

  localparam int NB = 3, NR = 2, AL = 8, SL = 9, DW = 12, DEPTH = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 hs_fill_start, hs_val_valid, hs_has_next_angle, pr_next_angle;
  logic [AL-1:0]        hs_angle;
  logic [DW-1:0]        hs_val;
  logic                 hs_fill_ready, hs_fill_done, pr_next_angle_ack, pr_working, all_done;
  logic [AL-1:0]        pr_angle;
  logic [NR*SL-1:0]     pr_s_val;
  logic [NR*DW-1:0]     pr_val;

  int checks = 0;
  int errors = 0;
  logic [NR*DW-1:0] sb_q[$];

  nabp_multi_bank_filtered_ram #(
    .NUM_BANKS(NB), .NUM_READERS(NR), .kAngleLength(AL), .kSLength(SL),
    .kFilteredDataLength(DW), .kDepth(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .hs_fill_start(hs_fill_start), .hs_angle(hs_angle),
    .hs_val_valid(hs_val_valid), .hs_val(hs_val),
    .hs_has_next_angle(hs_has_next_angle),
    .hs_fill_ready(hs_fill_ready), .hs_fill_done(hs_fill_done),
    .pr_next_angle(pr_next_angle), .pr_next_angle_ack(pr_next_angle_ack),
    .pr_angle(pr_angle), .pr_working(pr_working),
    .pr_s_val(pr_s_val), .pr_val(pr_val), .all_done(all_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive two read addresses, queue the expected data, compare one cycle later.
  task automatic rd(input logic [SL-1:0] s0, input logic [SL-1:0] s1,
                    input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    logic [NR*DW-1:0] exp;
    pr_s_val = {s1, s0};
    sb_q.push_back({e1, e0});
    tick();
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      exp = sb_q.pop_front();
      chk("pr_val", 32'(pr_val), 32'(exp));
    end
  endtask

  task automatic fill(input logic [AL-1:0] a, input int base, input bit req_on_last);
    hs_fill_start = 1'b1;
    hs_angle      = a;
    tick();
    hs_fill_start = 1'b0;
    chk("ready_while_filling", 32'(hs_fill_ready), 32'd0);
    for (int k = 0; k < DEPTH; k++) begin
      hs_val_valid = 1'b1;
      hs_val       = DW'(base + k);
      if (k == DEPTH - 1 && req_on_last) pr_next_angle = 1'b1;
      tick();
      if (k == DEPTH - 2) chk("done_early", 32'(hs_fill_done), 32'd0);
    end
    hs_val_valid = 1'b0;
    chk("fill_done", 32'(hs_fill_done), 32'd1);
    chk("ack_at_done", 32'(pr_next_angle_ack), 32'd0);
  endtask

  task automatic swap_chk(input logic [AL-1:0] a);
    chk("swap_ack", 32'(pr_next_angle_ack), 32'd1);
    chk("swap_angle", 32'(pr_angle), 32'(a));
    chk("swap_working", 32'(pr_working), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    hs_fill_start = 1'b0; hs_angle = '0; hs_val_valid = 1'b0; hs_val = '0;
    hs_has_next_angle = 1'b1; pr_next_angle = 1'b0; pr_s_val = '0;
    tick(); tick();
    chk("rst_ready", 32'(hs_fill_ready), 32'd0);
    chk("rst_working", 32'(pr_working), 32'd0);
    chk("rst_done", 32'(hs_fill_done), 32'd0);
    chk("rst_all_done", 32'(all_done), 32'd0);
    chk("rst_pr_val", 32'(pr_val), 32'd0);
    reset = 1'b0;
    tick();
    chk("ready_after_rst", 32'(hs_fill_ready), 32'd1);

    // Request held across the whole first fill; swap lands the cycle after done.
    pr_next_angle = 1'b1;
    fill(8'd5, 10, 1'b0);
    tick();
    swap_chk(8'd5);
    pr_next_angle = 1'b0;
    rd(9'd3, 9'd7, 12'd13, 12'd17);
    chk("ack_pulse", 32'(pr_next_angle_ack), 32'd0);
    rd(9'h1FF, 9'd8, 12'd0, 12'd0);

    // Request rises on the 8th write of the next line.
    fill(8'd6, 60, 1'b1);
    tick();
    swap_chk(8'd6);
    pr_next_angle = 1'b0;
    rd(9'd0, 9'd7, 12'd60, 12'd67);

    // Drain the last line.
    hs_has_next_angle = 1'b0;
    pr_next_angle = 1'b1;
    tick();
    pr_next_angle = 1'b0;
    chk("drain_working", 32'(pr_working), 32'd0);
    chk("drain_all_done", 32'(all_done), 32'd1);
    chk("drain_angle", 32'(pr_angle), 32'd0);
    chk("drain_no_ack", 32'(pr_next_angle_ack), 32'd0);
    rd(9'd0, 9'd1, 12'd0, 12'd0);
    hs_has_next_angle = 1'b1;
    fill(8'd7, 70, 1'b0);
    chk("all_done_cleared", 32'(all_done), 32'd0);
    pr_next_angle = 1'b1;
    tick();
    swap_chk(8'd7);
    pr_next_angle = 1'b0;
    rd(9'd2, 9'd5, 12'd72, 12'd75);

    // Fresh start: three fills with no request fill every bank.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    fill(8'd1, 20, 1'b0);
    chk("ready_after_fill1", 32'(hs_fill_ready), 32'd1);
    fill(8'd2, 30, 1'b0);
    fill(8'd3, 40, 1'b0);
    chk("ready_all_full", 32'(hs_fill_ready), 32'd0);
    pr_next_angle = 1'b1;
    tick();
    pr_next_angle = 1'b0;
    swap_chk(8'd1);
    chk("ready_first_swap", 32'(hs_fill_ready), 32'd0);
    rd(9'd0, 9'd5, 12'd20, 12'd25);
    pr_next_angle = 1'b1;
    tick();
    pr_next_angle = 1'b0;
    swap_chk(8'd2);
    chk("ready_bank0_freed", 32'(hs_fill_ready), 32'd1);
    rd(9'd2, 9'd6, 12'd32, 12'd36);

    // Reset in the middle of a fill into bank 0.
    hs_fill_start = 1'b1;
    hs_angle = 8'd9;
    tick();
    hs_fill_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      hs_val_valid = 1'b1;
      hs_val = DW'(90 + k);
      tick();
    end
    hs_val_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_ready", 32'(hs_fill_ready), 32'd0);
    chk("midrst_working", 32'(pr_working), 32'd0);
    chk("midrst_angle", 32'(pr_angle), 32'd0);
    chk("midrst_pr_val", 32'(pr_val), 32'd0);
    chk("midrst_done", 32'(hs_fill_done), 32'd0);
    chk("midrst_ack", 32'(pr_next_angle_ack), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("ready_after_midrst", 32'(hs_fill_ready), 32'd1);
    fill(8'd9, 50, 1'b0);
    pr_next_angle = 1'b1;
    tick();
    pr_next_angle = 1'b0;
    swap_chk(8'd9);
    rd(9'd1, 9'd4, 12'd51, 12'd54);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
